display_sequencer: RTL and testbench
====================================

Name: display_sequencer

Overview:
- Game-level controller for the board display path in the tile-matching game.
- Owns the game state (idle / playing / over / quit), a BCD match score and a countdown time bar.
- Drives the holder signals consumed by the 7-segment/LEDR display block: hex0hldr, hex4hldr, hex5hldr, ledrhldr, ingameOn, gameOver.
- Sits between the game logic (match/mismatch pulses, start, userquit) and the display block.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second tick. Must be >= 2.
- BAR_STEP, 6: seconds per LEDR bar segment. Game length is 10*BAR_STEP seconds.
- FLASH_CYCLES, 25000000: clk cycles that a match/mismatch flash overrides LEDR.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: start a game / acknowledge an end screen
- userquit  in  1  one-cycle pulse: player abandons the game
- match_pulse  in  1  one-cycle pulse: tile pair matched
- mismatch_pulse  in  1  one-cycle pulse: tile pair mismatched
- ingameOn  out  1  high while in PLAY
- gameOver  out  1  high while in OVER
- hex0hldr  out  4  mode code: 0 IDLE, 1 PLAY, 2 OVER, 3 QUIT
- hex4hldr  out  4  score ones digit (BCD), or 4'hF = blank
- hex5hldr  out  4  score tens digit (BCD), or 4'hF = blank
- ledrhldr  out  10  time bar or flash pattern

Behaviour:
- Clock and reset: single clock. resetn is asynchronous, active-low, and returns to IDLE whenever asserted, including mid-game.
- All outputs are registered. Reset values:
  - ingameOn=0, gameOver=0
  - hex0hldr=0, hex4hldr=F, hex5hldr=F
  - ledrhldr=0
  - score=00, bar=0, all counters 0, flash inactive
- Output latency: every output reflects a state or counter change one clk after the causing edge.
- State transitions (evaluated each clk):
  - IDLE: on start -> PLAY. Entry clears score to 00, loads bar=10, clears the tick counter, second counter and flash.
  - PLAY: userquit -> QUIT. Otherwise, bar reaching 0 or score reaching 99 -> OVER. Otherwise stay.
  - OVER: on start -> PLAY, with the same initialisation as IDLE->PLAY.
  - QUIT: on start -> IDLE.
  - Every other input is ignored outside PLAY.
- Priority within PLAY on the same cycle: userquit > timeout > match > mismatch.
  - A match arriving on the timeout cycle still scores. The resulting score is shown in OVER.
  - When userquit wins, a same-cycle match is discarded.
- Tick generation: in PLAY only, a counter runs 0..TICK_DIV-1 and emits a one-cycle tick on wrap. It holds at 0 in all other states.
- Time bar:
  - A second counter runs 0..BAR_STEP-1 and advances on tick.
  - On its wrap, bar decrements by 1, saturating at 0.
  - bar==0 while in PLAY forces the transition to OVER on the next edge.
- Score:
  - Two-digit BCD. match_pulse in PLAY increments it: ones digit 9 wraps to 0 with a carry into tens.
  - Saturates at 99. Reaching 99 ends the game (win).
  - mismatch_pulse never changes the score.
- Flash:
  - A match or mismatch pulse in PLAY loads the flash counter to FLASH_CYCLES and records its type.
  - A new pulse during an active flash restarts the counter and replaces the type.
  - The flash is cleared when leaving PLAY.
- Outputs per state:
  - IDLE: hex0=0, hex4/5=F, LEDR=0.
  - PLAY: hex0=1, hex5:hex4=score. LEDR = flash pattern while flash is active (match 10'h3FF, mismatch 10'h155), otherwise a thermometer of bar (lowest `bar` bits set).
  - OVER: hex0=2, hex5:hex4 hold the final score, LEDR=0.
  - QUIT: hex0=3, hex4/5=F, LEDR=0.
- Mode flags: ingameOn=1 only in PLAY; gameOver=1 only in OVER.

Decomposition:
- Shared package:
  - state enum (IDLE=0, PLAY=1, OVER=2, QUIT=3; doubles as the hex0 code)
  - HEX_BLANK=4'hF
  - LED_MATCH=10'h3FF, LED_MISS=10'h155
- One sub-module: bcd_score_counter, with clr, inc, two 4-bit digits, saturation at 99 and a max flag.

Test Plan (bench uses TICK_DIV=4, BAR_STEP=2, FLASH_CYCLES=3):
- Reset, then start -> one clk later: hex0=1, hex5/4=0/0, LEDR=10'h3FF, ingameOn=1.
- Start, then no activity for 10*2*4=80 clks after entry -> bar drops one LED every 8 clks, state reaches OVER (hex0=2, gameOver=1, LEDR=0) one clk after bar hits 0.
- In PLAY: 13 match pulses -> hex5=1, hex4=3. mismatch pulse -> LEDR=10'h155 for 3 clks, score unchanged. Match during that flash -> LEDR=10'h3FF for 3 clks.
- In PLAY: match and userquit on the same clk -> QUIT (hex0=3, hex4/5=F), and a later start returns to IDLE without the score ever incrementing.
- 100 match pulses -> score saturates at 99, OVER entered, further pulses ignored. Start -> PLAY with score 00.
- Deassert resetn mid-PLAY, asynchronously between clk edges -> all outputs at reset values immediately, and IDLE after release.

Source files
------------

// File: rtl/display_sequencer_pkg.sv
// Shared definitions for the board display sequencer: game state codes
// (which double as the hex0 mode digit), display constants and the
// time-bar thermometer helper.
package display_sequencer_pkg;

  // Game state; the encoding is also the value shown on hex0.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PLAY = 2'd1;
  localparam state_t ST_OVER = 2'd2;
  localparam state_t ST_QUIT = 2'd3;

  localparam logic [3:0] HEX_BLANK = 4'hF;
  localparam logic [9:0] LED_MATCH = 10'h3FF;
  localparam logic [9:0] LED_MISS  = 10'h155;

  // Number of bar segments at the start of a game.
  localparam logic [3:0] BAR_FULL = 4'd10;

  // Lowest `level` LEDs lit; levels above 10 light the whole bar.
  function automatic logic [9:0] thermometer(input logic [3:0] level);
    logic [9:0] t;
    for (int i = 0; i < 10; i++) begin
      t[i] = (i < int'(level));
    end
    return t;
  endfunction

endpackage

// File: rtl/display_sequencer_bcd_score.sv
// Two-digit BCD score counter that saturates at 99. Exposes the next-cycle
// digits so the parent can register display outputs in step with the score.
module bcd_score_counter (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] ones_next,
  output logic [3:0] tens_next,
  output logic       at_max
);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;

  assign at_max    = (tens_q == 4'd9) && (ones_q == 4'd9);
  assign ones_next = ones_d;
  assign tens_next = tens_d;

  // Next score: clear wins over increment, increment stops at 99.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (inc && !at_max) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Score digit registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// Game-level controller for the board display: runs the idle/play/over/quit
// state machine, the one-second tick, the countdown time bar, the BCD score
// and the match/mismatch flash, and registers the holder signals consumed
// by the 7-segment/LEDR display block.
module display_sequencer #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int BAR_STEP     = 6,
  parameter int FLASH_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       userquit,
  input  logic       match_pulse,
  input  logic       mismatch_pulse,
  output logic       ingameOn,
  output logic       gameOver,
  output logic [3:0] hex0hldr,
  output logic [3:0] hex4hldr,
  output logic [3:0] hex5hldr,
  output logic [9:0] ledrhldr
);

  import display_sequencer_pkg::*;

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (BAR_STEP > 1) ? $clog2(BAR_STEP) : 1;
  localparam int FW = $clog2(FLASH_CYCLES + 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]   sec_cnt_q, sec_cnt_d;
  logic [3:0]      bar_q, bar_d;
  logic [FW-1:0]   flash_cnt_q, flash_cnt_d;
  logic            flash_match_q, flash_match_d;

  logic            tick;
  logic            enter_play;
  logic            score_clr, score_inc, score_max;
  logic [3:0]      ones_next, tens_next;

  logic            ingame_q, ingame_d;
  logic            over_q, over_d;
  logic [3:0]      hex0_q, hex0_d;
  logic [3:0]      hex4_q, hex4_d;
  logic [3:0]      hex5_q, hex5_d;
  logic [9:0]      led_q, led_d;

  bcd_score_counter u_score (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (score_clr),
    .inc       (score_inc),
    .ones_next (ones_next),
    .tens_next (tens_next),
    .at_max    (score_max)
  );

  // Next game state, tick/second/bar counters, flash and score control.
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    sec_cnt_d     = sec_cnt_q;
    bar_d         = bar_q;
    flash_cnt_d   = flash_cnt_q;
    flash_match_d = flash_match_q;
    tick          = 1'b0;
    enter_play    = 1'b0;
    score_clr     = 1'b0;
    score_inc     = 1'b0;

    case (state_q)
      ST_IDLE: if (start) enter_play = 1'b1;
      ST_PLAY: begin
        if (userquit) begin
          // Quit wins outright; a same-cycle match is dropped.
          state_d = ST_QUIT;
        end else begin
          if ((bar_q == 4'd0) || score_max) state_d = ST_OVER;
          // A match on the timeout cycle still scores and shows in OVER.
          score_inc = match_pulse;

          if (tick_cnt_q == TW'(TICK_DIV - 1)) begin
            tick_cnt_d = '0;
            tick       = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end

          if (tick) begin
            if (sec_cnt_q == SW'(BAR_STEP - 1)) begin
              sec_cnt_d = '0;
              if (bar_q != 4'd0) bar_d = bar_q - 1'b1;
            end else begin
              sec_cnt_d = sec_cnt_q + 1'b1;
            end
          end

          // A new pulse restarts the flash; match outranks mismatch.
          if (match_pulse || mismatch_pulse) begin
            flash_cnt_d   = FW'(FLASH_CYCLES);
            flash_match_d = match_pulse;
          end else if (flash_cnt_q != '0) begin
            flash_cnt_d = flash_cnt_q - 1'b1;
          end
        end

        // Counters and flash only live inside PLAY.
        if (state_d != ST_PLAY) begin
          tick_cnt_d    = '0;
          sec_cnt_d     = '0;
          flash_cnt_d   = '0;
          flash_match_d = 1'b0;
        end
      end
      ST_OVER: if (start) enter_play = 1'b1;
      ST_QUIT: if (start) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (enter_play) begin
      state_d       = ST_PLAY;
      score_clr     = 1'b1;
      bar_d         = BAR_FULL;
      tick_cnt_d    = '0;
      sec_cnt_d     = '0;
      flash_cnt_d   = '0;
      flash_match_d = 1'b0;
    end
  end

  // Display holders computed from next-state values so they update on the
  // same edge as the state they describe.
  always_comb begin
    ingame_d = 1'b0;
    over_d   = 1'b0;
    hex0_d   = {2'b00, state_d};
    hex4_d   = HEX_BLANK;
    hex5_d   = HEX_BLANK;
    led_d    = '0;
    case (state_d)
      ST_PLAY: begin
        ingame_d = 1'b1;
        hex4_d   = ones_next;
        hex5_d   = tens_next;
        if (flash_cnt_d != '0) led_d = flash_match_d ? LED_MATCH : LED_MISS;
        else                   led_d = thermometer(bar_d);
      end
      ST_OVER: begin
        over_d = 1'b1;
        hex4_d = ones_next;
        hex5_d = tens_next;
      end
      default: ;
    endcase
  end

  // Control state and output registers.
  // NOTE: all control flops and output holders take the async reset; there is no storage array here that could be left unreset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      tick_cnt_q    <= '0;
      sec_cnt_q     <= '0;
      bar_q         <= 4'd0;
      flash_cnt_q   <= '0;
      flash_match_q <= 1'b0;
      ingame_q      <= 1'b0;
      over_q        <= 1'b0;
      hex0_q        <= 4'd0;
      hex4_q        <= HEX_BLANK;
      hex5_q        <= HEX_BLANK;
      led_q         <= '0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      sec_cnt_q     <= sec_cnt_d;
      bar_q         <= bar_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_match_q <= flash_match_d;
      ingame_q      <= ingame_d;
      over_q        <= over_d;
      hex0_q        <= hex0_d;
      hex4_q        <= hex4_d;
      hex5_q        <= hex5_d;
      led_q         <= led_d;
    end
  end

  assign ingameOn = ingame_q;
  assign gameOver = over_q;
  assign hex0hldr = hex0_q;
  assign hex4hldr = hex4_q;
  assign hex5hldr = hex5_q;
  assign ledrhldr = led_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer. The main instance uses the short
// timing (80-cycle game); a second instance with a longer tick runs the
// score-saturation scenario, which needs more than 80 cycles of play.
module tb_display_sequencer;

  logic clk;
  logic resetn;
  logic start, userquit, match_pulse, mismatch_pulse;

  logic       ingame_on, game_over;
  logic [3:0] hex0, hex4, hex5;
  logic [9:0] ledr;

  logic       l_ingame_on, l_game_over;
  logic [3:0] l_hex0, l_hex4, l_hex5;
  logic [9:0] l_ledr;

  int checks = 0;
  int errors = 0;

  display_sequencer #(.TICK_DIV(4), .BAR_STEP(2), .FLASH_CYCLES(3)) u_dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .userquit       (userquit),
    .match_pulse    (match_pulse),
    .mismatch_pulse (mismatch_pulse),
    .ingameOn       (ingame_on),
    .gameOver       (game_over),
    .hex0hldr       (hex0),
    .hex4hldr       (hex4),
    .hex5hldr       (hex5),
    .ledrhldr       (ledr)
  );

  display_sequencer #(.TICK_DIV(8), .BAR_STEP(2), .FLASH_CYCLES(3)) u_dut_long (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .userquit       (userquit),
    .match_pulse    (match_pulse),
    .mismatch_pulse (mismatch_pulse),
    .ingameOn       (l_ingame_on),
    .gameOver       (l_game_over),
    .hex0hldr       (l_hex0),
    .hex4hldr       (l_hex4),
    .hex5hldr       (l_hex5),
    .ledrhldr       (l_ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output bundles: {ingameOn, gameOver, hex0, hex5, hex4, ledr}.
  wire [23:0] obs   = {ingame_on, game_over, hex0, hex5, hex4, ledr};
  wire [23:0] obs_l = {l_ingame_on, l_game_over, l_hex0, l_hex5, l_hex4, l_ledr};

  // Expected bundle for a mode (0 idle, 1 play, 2 over, 3 quit).
  function automatic logic [23:0] exp_vec(input int mode, input logic [3:0] tens,
                                          input logic [3:0] ones, input logic [9:0] led);
    return {mode == 1, mode == 2, 4'(mode), tens, ones, led};
  endfunction

  function automatic logic [9:0] therm(input int n);
    logic [9:0] t;
    for (int i = 0; i < 10; i++) t[i] = (i < n);
    return t;
  endfunction

  // One clock of stimulus; pulses drop 1ns after the edge, where outputs are sampled.
  task automatic cyc(input logic s, input logic uq, input logic m, input logic mm);
    start = s; userquit = uq; match_pulse = m; mismatch_pulse = mm;
    @(posedge clk);
    #1;
    start = 1'b0; userquit = 1'b0; match_pulse = 1'b0; mismatch_pulse = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] e;
    e = exp_vec(0, 4'hF, 4'hF, 10'h000);
    #12;
    if (obs !== e) begin errors++; $display("FAIL reset_held: got %h want %h", obs, e); end
    checks++;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    if (obs !== e) begin errors++; $display("FAIL reset_release: got %h want %h", obs, e); end
    checks++;
    if (obs_l !== e) begin errors++; $display("FAIL reset_long: got %h want %h", obs_l, e); end
    checks++;
  endtask

  task automatic test_start();
    logic [23:0] e;
    cyc(1, 0, 0, 0);
    e = exp_vec(1, 4'd0, 4'd0, 10'h3FF);
    if (obs !== e) begin errors++; $display("FAIL start_play: got %h want %h", obs, e); end
    checks++;
  endtask

  // Continues from the start edge: bar loses one LED every 8 clocks.
  task automatic test_timeout();
    logic [23:0] e;
    for (int k = 1; k <= 81; k++) begin
      cyc(0, 0, 0, 0);
      if (k <= 80) e = exp_vec(1, 4'd0, 4'd0, therm(10 - k / 8));
      else         e = exp_vec(2, 4'd0, 4'd0, 10'h000);
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout_k%0d: got %h want %h", k, obs, e);
      end
      checks++;
    end
  endtask

  task automatic test_score_flash();
    logic [23:0] e;
    cyc(1, 0, 0, 0);                                   // E0: new game from OVER
    e = exp_vec(1, 4'd0, 4'd0, 10'h3FF);
    if (obs !== e) begin errors++; $display("FAIL restart_from_over: got %h want %h", obs, e); end
    checks++;
    for (int i = 1; i <= 13; i++) cyc(0, 0, 1, 0);    // E1..E13
    e = exp_vec(1, 4'd1, 4'd3, 10'h3FF);
    if (obs !== e) begin errors++; $display("FAIL score_13: got %h want %h", obs, e); end
    checks++;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);      // E14..E16: flash ends, bar=8
    e = exp_vec(1, 4'd1, 4'd3, 10'h0FF);
    if (obs !== e) begin errors++; $display("FAIL flash_expired: got %h want %h", obs, e); end
    checks++;
    cyc(0, 0, 0, 1);                                   // E17..E19: mismatch flash
    for (int i = 0; i < 3; i++) begin
      e = exp_vec(1, 4'd1, 4'd3, 10'h155);
      if (obs !== e) begin errors++; $display("FAIL miss_flash_%0d: got %h want %h", i, obs, e); end
      checks++;
      if (i < 2) cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0);                                   // E20
    e = exp_vec(1, 4'd1, 4'd3, 10'h0FF);
    if (obs !== e) begin errors++; $display("FAIL miss_flash_end: got %h want %h", obs, e); end
    checks++;
    cyc(0, 0, 0, 1);                                   // E21: mismatch
    cyc(0, 0, 1, 0);                                   // E22: match replaces it
    for (int i = 0; i < 3; i++) begin                  // E22..E24
      e = exp_vec(1, 4'd1, 4'd4, 10'h3FF);
      if (obs !== e) begin errors++; $display("FAIL match_over_miss_%0d: got %h want %h", i, obs, e); end
      checks++;
      if (i < 2) cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0);                                   // E25: bar=7
    e = exp_vec(1, 4'd1, 4'd4, 10'h07F);
    if (obs !== e) begin errors++; $display("FAIL match_flash_end: got %h want %h", obs, e); end
    checks++;
  endtask

  task automatic test_quit();
    logic [23:0] e;
    cyc(0, 1, 1, 0);
    e = exp_vec(3, 4'hF, 4'hF, 10'h000);
    if (obs !== e) begin errors++; $display("FAIL quit_with_match: got %h want %h", obs, e); end
    checks++;
    cyc(0, 0, 1, 1);
    if (obs !== e) begin errors++; $display("FAIL quit_ignores_pulses: got %h want %h", obs, e); end
    checks++;
    cyc(1, 0, 0, 0);
    e = exp_vec(0, 4'hF, 4'hF, 10'h000);
    if (obs !== e) begin errors++; $display("FAIL quit_to_idle: got %h want %h", obs, e); end
    checks++;
    cyc(1, 0, 0, 0);
    e = exp_vec(1, 4'd0, 4'd0, 10'h3FF);
    if (obs !== e) begin errors++; $display("FAIL idle_to_play: got %h want %h", obs, e); end
    checks++;
  endtask

  task automatic test_async_reset();
    logic [23:0] e;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    e = exp_vec(1, 4'd0, 4'd2, 10'h3FF);
    if (obs !== e) begin errors++; $display("FAIL pre_reset_score: got %h want %h", obs, e); end
    checks++;
    #2;
    resetn = 1'b0;
    #1;
    e = exp_vec(0, 4'hF, 4'hF, 10'h000);
    if (obs !== e) begin errors++; $display("FAIL async_reset_now: got %h want %h", obs, e); end
    checks++;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cyc(0, 0, 1, 0);
    if (obs !== e) begin errors++; $display("FAIL idle_after_reset: got %h want %h", obs, e); end
    checks++;
  endtask

  // Runs on the long-tick instance: 100 back-to-back matches.
  task automatic test_saturate();
    logic [23:0] e;
    int s;
    cyc(1, 0, 0, 0);
    e = exp_vec(1, 4'd0, 4'd0, 10'h3FF);
    if (obs_l !== e) begin errors++; $display("FAIL sat_start: got %h want %h", obs_l, e); end
    checks++;
    for (int i = 1; i <= 102; i++) begin
      cyc(0, 0, 1, 0);
      s = (i > 99) ? 99 : i;
      if (i <= 99) e = exp_vec(1, 4'(s / 10), 4'(s % 10), 10'h3FF);
      else         e = exp_vec(2, 4'd9, 4'd9, 10'h000);
      if (obs_l !== e) begin
        errors++;
        $display("FAIL sat_match_%0d: got %h want %h", i, obs_l, e);
      end
      checks++;
    end
    cyc(1, 0, 0, 0);
    e = exp_vec(1, 4'd0, 4'd0, 10'h3FF);
    if (obs_l !== e) begin errors++; $display("FAIL sat_restart: got %h want %h", obs_l, e); end
    checks++;
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0; userquit = 1'b0; match_pulse = 1'b0; mismatch_pulse = 1'b0;
    test_reset();
    test_start();
    test_timeout();
    test_score_flash();
    test_quit();
    test_async_reset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
